// File: rtl/cipher_round_seq.sv
// Iteration sequencer for an external cipher round function: initial key add, then NUM_ROUNDS rounds.
// Define CIPHER_ROUND_SEQ_PREFETCH_EN to add a one-deep request buffer for back-to-back operation.
module cipher_round_seq #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] rnd_data_o,
  output logic [KEY_W-1:0]  rnd_key_o,
  output logic              rnd_first_o,
  output logic              rnd_final_o,
  output logic [7:0]        rnd_const_o,
  input  logic [DATA_W-1:0] rnd_data_i,
  input  logic [KEY_W-1:0]  rnd_key_i
);

  localparam int CNT_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              fsm_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [7:0]          rc_reg;
  logic [7:0]          rc_next;
  logic [DATA_W-1:0]   blk_reg;
  logic [KEY_W-1:0]    key_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic                done_reg;
  logic                is_run;
  logic                is_last;
  logic                load_ok;

`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
  logic                pend_valid_reg;
  logic [DATA_W-1:0]   pend_data_reg;
  logic [KEY_W-1:0]    pend_key_reg;
`endif

  // GF(2^8) doubling with the AES reduction polynomial.
  assign rc_next = {rc_reg[6:0], 1'b0} ^ (rc_reg[7] ? 8'h1B : 8'h00);

  assign is_run  = (fsm_reg == RUN);
  assign is_last = is_run && (cnt_reg == LAST_CNT);

`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
  assign ready_o = ~rst & (~is_run | ~pend_valid_reg);
`else
  assign ready_o = ~rst & ~is_run;
`endif

  // Abort takes priority over any request presented in the same cycle.
  assign load_ok = load_i & ready_o & ~abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg        <= IDLE;
      cnt_reg        <= '0;
      rc_reg         <= '0;
      blk_reg        <= '0;
      key_reg        <= '0;
      data_out_reg   <= '0;
      done_reg       <= 1'b0;
`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      pend_key_reg   <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (load_ok) begin
            fsm_reg <= RUN;
            blk_reg <= data_i;
            key_reg <= key_i;
            cnt_reg <= '0;
            rc_reg  <= 8'h01;
          end
        end
        RUN: begin
          if (abort_i) begin
            fsm_reg <= IDLE;
            cnt_reg <= '0;
            rc_reg  <= '0;
`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
            pend_valid_reg <= 1'b0;
`endif
          end else if (is_last) begin
            data_out_reg <= rnd_data_i;
            done_reg     <= 1'b1;
            blk_reg      <= rnd_data_i;
            key_reg      <= rnd_key_i;
            cnt_reg      <= '0;
`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
            // Chain straight into the next block so busy never drops.
            if (pend_valid_reg) begin
              blk_reg        <= pend_data_reg;
              key_reg        <= pend_key_reg;
              rc_reg         <= 8'h01;
              pend_valid_reg <= 1'b0;
            end else if (load_ok) begin
              blk_reg <= data_i;
              key_reg <= key_i;
              rc_reg  <= 8'h01;
            end else begin
              fsm_reg <= IDLE;
              rc_reg  <= '0;
            end
`else
            fsm_reg <= IDLE;
            rc_reg  <= '0;
`endif
          end else begin
            blk_reg <= rnd_data_i;
            key_reg <= rnd_key_i;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg != '0) begin
              rc_reg <= rc_next;
            end
`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
            if (load_ok) begin
              pend_valid_reg <= 1'b1;
              pend_data_reg  <= data_i;
              pend_key_reg   <= key_i;
            end
`endif
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign busy_o      = is_run;
  assign done_o      = done_reg;
  assign data_o      = data_out_reg;
  assign rnd_data_o  = blk_reg;
  assign rnd_key_o   = key_reg;
  assign rnd_first_o = is_run && (cnt_reg == '0);
  assign rnd_final_o = is_last;
  assign rnd_const_o = (is_run && (cnt_reg != '0)) ? rc_reg : 8'h00;

endmodule

// File: tb/tb_cipher_round_seq.sv
// Bench for cipher_round_seq: a 10-round and a 14-round instance share stimulus and a stub round function.
// Honours CIPHER_ROUND_SEQ_PREFETCH_EN for the buffered-request scenario.
module tb_cipher_round_seq;

  localparam int NI = 2;
  localparam int DW = 128;
`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] key_i = '0;

  logic [NI-1:0] ready_o, busy_o, done_o, first_o, final_o;
  logic [7:0]    const_o [NI];
  logic [DW-1:0] dout [NI];
  logic [DW-1:0] rdo [NI];
  logic [DW-1:0] rko [NI];
  logic [DW-1:0] rdi [NI];
  logic [DW-1:0] rki [NI];

  int total = 0;
  int bad = 0;

  logic [7:0] rc_tbl [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      cipher_round_seq #(
        .DATA_W(DW), .KEY_W(DW), .NUM_ROUNDS(gi == 0 ? 10 : 14)
      ) u_dut (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .key_i(key_i),
        .abort_i(abort_i), .ready_o(ready_o[gi]), .busy_o(busy_o[gi]), .done_o(done_o[gi]),
        .data_o(dout[gi]), .rnd_data_o(rdo[gi]), .rnd_key_o(rko[gi]),
        .rnd_first_o(first_o[gi]), .rnd_final_o(final_o[gi]), .rnd_const_o(const_o[gi]),
        .rnd_data_i(rdi[gi]), .rnd_key_i(rki[gi])
      );
      assign rdi[gi] = rdo[gi] ^ rko[gi];
      assign rki[gi] = rko[gi] + 1'b1;
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  // Round constant of iteration p (p >= 1): x^(p-1) in GF(2^8).
  function automatic logic [7:0] rc_of(input int p);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < p; j++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    return r;
  endfunction

  // Stub-cipher state after p iterations: s0 xor k0 xor (k0+1) ... xor (k0+p-1).
  function automatic logic [DW-1:0] state_at(input logic [DW-1:0] s0, input logic [DW-1:0] k0,
                                             input int p);
    logic [DW-1:0] s;
    s = s0;
    for (int j = 0; j < p; j++) s = s ^ (k0 + DW'(j));
    return s;
  endfunction

  int            ph [NI] = '{-1, -1};
  logic [DW-1:0] ms0 [NI];
  logic [DW-1:0] mk0 [NI];
  logic [DW-1:0] exp_data [NI];
  logic          exp_done [NI];
  logic          pv [NI];
  logic [DW-1:0] pd [NI];
  logic [DW-1:0] pk [NI];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        ph[i] = -1; exp_data[i] = '0; exp_done[i] = 1'b0; pv[i] = 1'b0;
      end else begin
        exp_done[i] = 1'b0;
        if (ph[i] < 0) begin
          if (load_i && !abort_i) begin ms0[i] = data_i; mk0[i] = key_i; ph[i] = 0; end
        end else if (abort_i) begin
          ph[i] = -1; pv[i] = 1'b0;
        end else if (ph[i] == nr_of(i)) begin
          exp_data[i] = state_at(ms0[i], mk0[i], ph[i] + 1);
          exp_done[i] = 1'b1;
          ph[i] = -1;
          if (PREF && pv[i]) begin
            ms0[i] = pd[i]; mk0[i] = pk[i]; ph[i] = 0; pv[i] = 1'b0;
          end else if (PREF && load_i) begin
            ms0[i] = data_i; mk0[i] = key_i; ph[i] = 0;
          end
        end else begin
          ph[i] = ph[i] + 1;
          if (PREF && load_i && !pv[i]) begin pd[i] = data_i; pk[i] = key_i; pv[i] = 1'b1; end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ready%0d", i), ready_o[i], !rst && (ph[i] < 0 || (PREF && !pv[i])));
      chk($sformatf("busy%0d", i), busy_o[i], ph[i] >= 0);
      chk($sformatf("done%0d", i), done_o[i], exp_done[i]);
      chk($sformatf("data_o%0d", i), dout[i], exp_data[i]);
      chk($sformatf("first%0d", i), first_o[i], ph[i] == 0);
      chk($sformatf("final%0d", i), final_o[i], ph[i] == nr_of(i));
      chk($sformatf("const%0d", i), const_o[i], (ph[i] >= 1) ? rc_of(ph[i]) : 8'h00);
      if (ph[i] >= 0) begin
        chk($sformatf("rnd_data%0d", i), rdo[i], state_at(ms0[i], mk0[i], ph[i]));
        chk($sformatf("rnd_key%0d", i), rko[i], mk0[i] + DW'(ph[i]));
      end else if (rst) begin
        chk($sformatf("rnd_data_rst%0d", i), rdo[i], '0);
        chk($sformatf("rnd_key_rst%0d", i), rko[i], '0);
      end
      if (done_o[i]) $display("txn inst=%0d t=%0t data_o=%h", i, $time, dout[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [DW-1:0] d, input logic [DW-1:0] k);
    load_i = 1'b1; data_i = d; key_i = k;
    tick();
    load_i = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int n);
    n = 0;
    while (!done_o[i] && n < budget) begin tick(); n++; end
    if (!done_o[i]) begin
      total++; bad++;
      $display("FAIL done_timeout inst=%0d t=%0t got=no_done want=done", i, $time);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_o != '0) && n < budget) begin tick(); n++; end
    chk("idle_timeout", busy_o, '0);
  endtask

  initial begin
    int n, n0, bz, fh, fl, first_d, second_d, drops, dones;
    logic [DW-1:0] saved;

    #1 rst = 1'b1;
    #2;
    chk("rst_ready", ready_o[0], 1'b0);
    chk("rst_data_o", dout[0], '0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", ready_o, 2'b11);

    // Run 1: zero data/key, latency, flags and round constants.
    do_load('0, '0);
    n = 0; n0 = -1; bz = 0; fh = 0; fl = 0;
    while (!done_o[1] && n < 40) begin
      if (done_o[0]) n0 = n;
      if (busy_o[0]) bz++;
      if (first_o[0]) begin fh++; chk("first_at", n, 0); end
      if (final_o[0]) begin fl++; chk("final_at", n, 10); end
      if (n >= 1 && n <= 10) chk($sformatf("rc10_cnt%0d", n), const_o[0], rc_tbl[n-1]);
      if (n >= 11 && n <= 14) chk($sformatf("rc14_cnt%0d", n), const_o[1], rc_tbl[n-1]);
      tick(); n++;
    end
    chk("latency10", n0, 11);
    chk("latency14", n, 15);
    chk("busy_cycles10", bz, 11);
    chk("first_hits", fh, 1);
    chk("final_hits", fl, 1);
    chk("result10", dout[0], 128'h0B);
    chk("result14", dout[1], 128'h0F);
    wait_idle(40);

    // Run 2: wide operands with key wrap; load in the done cycle.
    do_load(128'h0123456789abcdef_fedcba9876543210, '1);
`ifndef CIPHER_ROUND_SEQ_PREFETCH_EN
    repeat (3) tick();
    chk("ready_while_busy", ready_o[0], 1'b0);
    load_i = 1'b1; data_i = 128'h5555; key_i = 128'h7;
    tick();
    load_i = 1'b0;
`endif
    wait_done(0, 30, n);
    do_load(128'hdeadbeef_00000000_cafef00d_12345678, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    chk("load_in_done_cycle", busy_o[0], 1'b1);
    wait_idle(80);

    // Abort at cnt=5 together with a load.
    saved = dout[0];
    do_load(128'h1111_2222_3333_4444, 128'h9999);
    repeat (5) tick();
    abort_i = 1'b1; load_i = 1'b1; data_i = 128'hAAAA; key_i = 128'hBBBB;
    tick();
    abort_i = 1'b0; load_i = 1'b0;
    chk("abort_busy", busy_o, 2'b00);
    chk("abort_data_kept", dout[0], saved);
    dones = 0;
    repeat (20) begin if (done_o != '0) dones++; tick(); end
    chk("abort_no_done", dones, 0);

    // Reset in the middle of an operation, then a clean run.
    do_load('0, '0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 2'b00);
    chk("midrst_ready", ready_o, 2'b00);
    chk("midrst_data_o", dout[0], '0);
    chk("midrst_rnd_data", rdo[0], '0);
    chk("midrst_const", const_o[0], 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_midrst", ready_o, 2'b11);
    do_load('0, '0);
    wait_done(0, 30, n);
    chk("fresh_latency", n, 11);
    chk("fresh_result", dout[0], 128'h0B);
    wait_idle(40);

`ifdef CIPHER_ROUND_SEQ_PREFETCH_EN
    // Second load at cnt=4 is buffered; third load while pending is refused.
    do_load(128'h1234, 128'h10);
    repeat (4) tick();
    do_load(128'h5678, 128'h20);
    chk("pend_ready", ready_o[0], 1'b0);
    load_i = 1'b1; data_i = 128'h9abc; key_i = 128'h30;
    tick();
    load_i = 1'b0;
    n = 6; first_d = -1; second_d = -1; drops = 0;
    while (second_d < 0 && n < 60) begin
      if (done_o[0] && first_d >= 0) second_d = n;
      else begin
        if (done_o[0]) first_d = n;
        if (first_d >= 0 && !busy_o[0]) drops++;
      end
      tick(); n++;
    end
    chk("pf_first_done", first_d, 11);
    chk("pf_second_done", second_d, 22);
    chk("pf_busy_drops", drops, 0);
    repeat (3) tick();
    chk("pf_third_ignored", busy_o[0], 1'b0);
    wait_idle(60);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cipher_round_seq.md
CIPHER_ROUND_SEQ -- requirements
Module: cipher_round_seq

Interface
REQ-001 Parameter DATA_W, 128, width of data block and round result.
REQ-002 Parameter KEY_W, 128, width of round key.
REQ-003 Parameter NUM_ROUNDS, 10, number of full rounds after initial key add; legal range 2..14.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 load_i  in  1  start request; sampled with data_i/key_i when ready_o=1.
REQ-007 data_i  in  DATA_W  plaintext block.
REQ-008 key_i  in  KEY_W  initial cipher key.
REQ-009 abort_i  in  1  cancel current operation.
REQ-010 ready_o  out  1  request can be accepted this cycle.
REQ-011 busy_o  out  1  operation in progress.
REQ-012 done_o  out  1  one-cycle pulse, data_o valid.
REQ-013 data_o  out  DATA_W  result; held until next done_o.
REQ-014 rnd_data_o  out  DATA_W  state register to external round function.
REQ-015 rnd_key_o  out  KEY_W  key register to external round function.
REQ-016 rnd_first_o  out  1  current iteration is initial key add.
REQ-017 rnd_final_o  out  1  current iteration is final round.
REQ-018 rnd_const_o  out  8  key-expansion round constant for current iteration.
REQ-019 rnd_data_i  in  DATA_W  combinational round-function result.
REQ-020 rnd_key_i  in  KEY_W  combinational next round key.

Function
REQ-021 States IDLE, RUN; iteration counter cnt runs 0..NUM_ROUNDS in RUN.
REQ-022 IDLE + accepted load: capture data_i/key_i into state/key regs, cnt=0, rc=0x01, go RUN.
REQ-023 RUN each edge: state<=rnd_data_i, key<=rnd_key_i, cnt<=cnt+1.
REQ-024 rnd_first_o=1 iff RUN and cnt=0; rnd_final_o=1 iff RUN and cnt=NUM_ROUNDS; both 0 in IDLE.
REQ-025 rnd_const_o=0x00 when cnt=0 or IDLE; else rc; rc advances by GF(2^8) xtime (shift left, XOR 0x1B if bit7 set) on each edge with cnt>=1.
REQ-026 Final edge (cnt=NUM_ROUNDS): data_o<=rnd_data_i, done_o=1 next cycle, go IDLE; busy_o=0 in that done_o cycle.
REQ-027 Latency: done_o high exactly NUM_ROUNDS+1 cycles after the load-sampling edge.
REQ-028 busy_o=1 iff RUN; ready_o=!busy_o (without macro).
REQ-029 load_i with ready_o=0: ignored, no state change.
REQ-030 abort_i in RUN: next edge go IDLE, no done_o, data_o unchanged, pending request discarded.
REQ-031 abort_i and load_i same cycle: abort wins, load dropped, no operation starts.
REQ-032 load_i in the done_o cycle: accepted normally (state is IDLE).

Reset
REQ-033 rst asserted: immediately IDLE, all outputs and internal regs 0 (ready_o=1 once out of reset).
REQ-034 rst mid-operation: operation lost, no done_o, data_o=0.

Configuration
REQ-035 Macro CIPHER_ROUND_SEQ_PREFETCH_EN defined: one-deep pending buffer; load in RUN with buffer empty is captured; ready_o=!busy_o | !pend_valid.
REQ-036 With macro, final edge with pend_valid: data_o/done_o as REQ-026, but next state RUN, cnt=0, rc=0x01, from buffer; busy_o stays 1; buffer cleared.
REQ-037 Without macro: no buffer, REQ-028/029 apply.

Verification (stub round fn: rnd_data_i=rnd_data_o^rnd_key_o, rnd_key_i=rnd_key_o+1)
REQ-038 Defaults, data_i=0, key_i=0, load 1 cycle -> done_o 11 cycles later, data_o=0x...0B, busy_o high 11 cycles.
REQ-039 Same run -> rnd_const_o sequence cnt1..10 = 01,02,04,08,10,20,40,80,1B,36; first/final flags only at cnt0/cnt10.
REQ-040 NUM_ROUNDS=14 -> rnd_const_o at cnt11..14 = 6C,D8,AB,4D; done_o 15 cycles after load.
REQ-041 abort_i at cnt=5 -> busy_o 0 next cycle, no done_o, data_o retains prior value; load same cycle as abort ignored.
REQ-042 rst pulsed at cnt=3 -> all outputs 0 asynchronously, no done_o; fresh load after release completes normally.
REQ-043 Prefetch macro, second load at cnt=4 -> two done_o pulses 11 cycles apart, busy_o never drops between; third load while pending -> ignored (ready_o=0).
